// File: rtl/mux3_pkg.sv
// Shared types and helpers for the 3:1 one-hot mux controllers.
// Holds the arbiter state encoding, the source count and a one-hot helper.
package mux3_pkg;

    localparam int N_SRC = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Index 3 has no source and maps to an all-zero select.
    function automatic logic [N_SRC-1:0] onehot(input logic [1:0] idx);
        onehot = N_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last+1, wrapping modulo N. Outputs are all-zero when req is zero.
module rr_pick
    import mux3_pkg::*;
#(
    parameter int N = N_SRC
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   last,
    output logic [N-1:0] pick_oh,
    output logic [1:0]   pick_id
);

    logic [2:0] pos;

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        pick_oh = '0;
        pick_id = '0;
        pos     = '0;
        for (int k = N; k >= 1; k--) begin
            pos = 3'(last) + 3'(k);
            if (pos >= 3'(N)) pos = pos - 3'(N);
            if (pos >= 3'(N)) pos = pos - 3'(N);
            if (req[pos[1:0]]) begin
                pick_oh          = '0;
                pick_oh[pos[1:0]] = 1'b1;
                pick_id          = pos[1:0];
            end
        end
    end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin owner selection for the shared 3:1 one-hot mux, with bounded
// hold time and a one-cycle all-zero gap between consecutive owners.
module mux3_rr_arbiter
    import mux3_pkg::*;
#(
    parameter int N        = N_SRC,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] sl,
    output logic [1:0]   gnt_id,
    output logic         busy,
    output logic         preempt,
    output state_t       state_dbg
);

    // Handshake: a source holds req high for as long as it wants the mux; it owns
    // the mux exactly while its sl bit is high, and dropping req ends ownership
    // at the next edge. Requests are not latched, only sampled when picking.

    localparam int             CW        = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_MAX  = CW'(MAX_HOLD);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t          state, state_d;
    logic [CW-1:0]   hold_cnt, hold_d;
    logic [1:0]      last, last_d;
    logic [N-1:0]    sl_d;
    logic [1:0]      gnt_id_d;
    logic            busy_d, preempt_d;

    logic [N-1:0]    pick_oh;
    logic [1:0]      pick_id;
    logic            owner_req;
    logic            timeout;

    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .last    (last),
        .pick_oh (pick_oh),
        .pick_id (pick_id)
    );

    // In GRANT, sl is the owner's one-hot, so it doubles as the owner mask.
    assign owner_req = |(req & sl);
    assign timeout   = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST) && (|(req & ~sl));

    always_comb begin
        state_d   = state;
        hold_d    = hold_cnt;
        last_d    = last;
        sl_d      = sl;
        gnt_id_d  = gnt_id;
        busy_d    = busy;
        preempt_d = 1'b0;
        case (state)
            IDLE, GAP: begin
                hold_d = '0;
                if (|req) begin
                    state_d  = GRANT;
                    sl_d     = pick_oh;
                    gnt_id_d = pick_id;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                    sl_d     = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                end
            end
            GRANT: begin
                if (!owner_req || timeout) begin
                    // Release takes priority, so preempt only marks a pure revocation.
                    state_d   = GAP;
                    last_d    = gnt_id;
                    sl_d      = '0;
                    gnt_id_d  = '0;
                    busy_d    = 1'b0;
                    hold_d    = '0;
                    preempt_d = owner_req;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                hold_d   = '0;
                sl_d     = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 2'(N - 1);
            sl       <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_d;
            last     <= last_d;
            sl       <= sl_d;
            gnt_id   <= gnt_id_d;
            busy     <= busy_d;
            preempt  <= preempt_d;
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/mux3_rr_arbiter.md
Name: mux3_rr_arbiter

Overview:
- Round-robin arbiter that shares the 3:1 one-hot-select mux between three requesters.
- Drives the mux `sl[2:0]` one-hot select from registered state, so the selection is glitch-free.
- Enforces a bounded hold time and a one-cycle break-before-make gap between owners.
- Sits directly in front of `mux3_1a`; its `sl` output connects to the mux `sl` input.

Parameters:
- N, 3, number of requesters; the mux select width; fixed at 3 for `mux3_1a`.
- MAX_HOLD, 4, maximum consecutive grant cycles while another requester waits; 0 disables the timeout.
- CW, $clog2(MAX_HOLD+1) (local), hold counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request per source; level-sensitive; held high for as long as ownership is wanted.
- sl  output  N  one-hot mux select, or all-zero when idle or in gap; registered.
- gnt_id  output  2  index of the current owner; 0 when sl is 0; registered.
- busy  output  1  high iff sl != 0; registered.
- preempt  output  1  one-cycle pulse in the first gap cycle after a timeout revocation.

Behaviour:
- Reset (async, rst_n=0): sl=0, gnt_id=0, busy=0, preempt=0, state=IDLE, hold_cnt=0, last=N-1, so req[0] has highest priority after reset.
- Reset mid-grant: all outputs clear immediately, without waiting for a clock edge; arbitration restarts from IDLE with last=N-1.
- States are IDLE, GRANT and GAP.
- IDLE:
  - req==0: stay in IDLE.
  - req!=0: at the next edge go to GRANT with sl=onehot(pick) and hold_cnt=0.
  - Latency from req rising to sl is 1 cycle.
- pick: the first set bit of req scanning from index last+1, wrapping modulo N.
- GRANT, owner o:
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Release: if req[o]==0 is sampled, go to GAP at the next edge and set last=o.
  - Timeout: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req & ~onehot(o))!=0. Go to GAP at the next edge, set last=o, and assert preempt for that GAP cycle. The owner therefore holds for exactly MAX_HOLD cycles.
  - Timeout condition reached but no other requester pending: keep the grant; hold_cnt stays saturated; re-evaluate every cycle.
  - Release and timeout in the same cycle: release wins and preempt stays 0.
- GAP:
  - sl=0 for exactly one cycle.
  - At the next edge: req!=0 goes to GRANT with the new pick (which may be the same source if only it requests); req==0 goes to IDLE.
- Invariant: sl is never multi-hot. $onehot0(sl) holds every cycle.
- Invariant: busy == |sl.
- Invariant: gnt_id matches the sl bit position.
- Requests asserted during GRANT or GAP are not latched; they are only seen if still high when pick is evaluated.
- Source-to-mux latency: data presented on a/b/c reaches the mux out combinationally in the same cycle sl selects it.

Decomposition:
- Shared package mux3_pkg holds:
  - state enum {IDLE, GRANT, GAP};
  - localparam N_SRC=3;
  - a function onehot(idx) returning N bits.
- One natural sub-module, rr_pick: purely combinational. Inputs req[N-1:0] and last[1:0]; outputs pick_oh[N-1:0] and pick_id[1:0]. It is reusable for any later N-way mux controller.
- The top module holds the FSM, hold counter, last pointer and registered outputs.

Test Plan:
- Reset/first grant: rst_n=0, then release with req=3'b111 → cycle 1 after release sl=001, gnt_id=0, busy=1.
- Timeout rotation (MAX_HOLD=4, req=3'b011 constant):
  - sl=001 for 4 cycles, then 000 for 1 cycle with preempt=1;
  - then sl=010 for 4 cycles, then gap, then 001;
  - preempt pulses exactly once per rotation.
- Single requester beyond timeout (req=3'b100 for 20 cycles) → sl=100 continuously, no gap, preempt=0.
- Early release (req=3'b101, source 0 drops req after 2 cycles) → sl=001 for 2 cycles, 000 for 1 cycle, then 100; preempt=0.
- Async reset mid-grant: assert rst_n=0 between clock edges while sl=010 → sl=000 and busy=0 before the next edge. After release with req=3'b110 → sl=010, because priority restarts at index 0.
- Integration with `mux3_1a`: a=0, b=1, c=0, req=3'b111, MAX_HOLD=2 → out sequence 0,0,gap,1,1,gap,0,0. Assert $onehot0(sl) and busy==|sl on every cycle.
